decim_avg_filter: RTL and testbench

Parametrised successor to the single-channel 1-bit filter/averager. Runs each accepted input sample through a signed 3-tap FIR (default second difference 1,-2,1). It then forms a true moving average over a power-of-two window, using a running sum rather than a re-summed buffer. A decimated result is emitted with a one-cycle valid strobe. Sits between the front-end sampler and downstream rate-reduced consumers.

---
 rtl/decim_avg_filter_if.sv | 15 +
 rtl/decim_avg_filter.sv | 114 +++++++++++
 tb/tb_decim_avg_filter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/decim_avg_filter_if.sv
// Sample/result bus for decim_avg_filter: accepted-sample input side and decimated output side.
`timescale 1ns/1ps
interface decim_avg_filter_if #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 8
);
  logic                    IN_VALID;
  logic [IN_W-1:0]         IN;
  logic signed [OUT_W-1:0] OUT;
  logic                    OUT_VALID;
  logic                    FILLED;

  modport master (output IN_VALID, IN, input OUT, OUT_VALID, FILLED);
  modport slave  (input IN_VALID, IN, output OUT, OUT_VALID, FILLED);
endinterface

// File: rtl/decim_avg_filter.sv
// 3-tap FIR -> power-of-two running-sum moving average -> decimated strobe output.
// Define DECIM_AVG_SAT_EN to clamp the average into OUT's range instead of wrapping.
`timescale 1ns/1ps
module decim_avg_filter #(
  parameter int IN_W     = 1,
  parameter int COEF_W   = 4,
  parameter int A0       = 1,
  parameter int A1       = -2,
  parameter int A2       = 1,
  parameter int LOG2_WIN = 6,
  parameter int DECIM    = 64,
  parameter int OUT_W    = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CLR,
  decim_avg_filter_if.slave bus
);
  localparam int D_W    = IN_W + COEF_W + 2;
  localparam int SUM_W  = D_W + LOG2_WIN;
  localparam int WIN    = 1 << LOG2_WIN;
  localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int STAGES = 2;

  localparam logic signed [D_W-1:0]    C0       = D_W'(A0);
  localparam logic signed [D_W-1:0]    C1       = D_W'(A1);
  localparam logic signed [D_W-1:0]    C2       = D_W'(A2);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [LOG2_WIN-1:0]      WP_LAST  = LOG2_WIN'(WIN - 1);

  logic [IN_W-1:0]         x1, x2;
  logic [CNT_W-1:0]        cnt;
  logic [STAGES-1:0]       vld_pipe, tag_pipe;
  logic signed [D_W-1:0]   xin, xm1, xm2, d_nxt, d_s1;
  logic signed [D_W-1:0]   win_mem [WIN];
  logic [LOG2_WIN-1:0]     wp;
  logic signed [SUM_W-1:0] sum, sum_nxt;
  logic                    filled, filled_s2;
  logic signed [OUT_W-1:0] out_q, out_nxt;
  logic                    out_vld;
  logic                    fire;

  // Samples are unsigned; zero-extend before the signed multiply.
  assign xin   = D_W'(bus.IN);
  assign xm1   = D_W'(x1);
  assign xm2   = D_W'(x2);
  assign d_nxt = C0 * xin + C1 * xm1 + C2 * xm2;

  assign sum_nxt = sum + {{LOG2_WIN{d_s1[D_W-1]}}, d_s1}
                       - {{LOG2_WIN{win_mem[wp][D_W-1]}}, win_mem[wp]};

`ifdef DECIM_AVG_SAT_EN
  localparam logic signed [SUM_W-1:0] OMAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OMIN = ~OMAX;
  logic signed [SUM_W-1:0] avg, avg_sat;
  always_comb begin
    avg     = sum >>> LOG2_WIN;
    avg_sat = avg;
    if (avg > OMAX)      avg_sat = OMAX;
    else if (avg < OMIN) avg_sat = OMIN;
    out_nxt = OUT_W'(avg_sat);
  end
`else
  assign out_nxt = OUT_W'(sum >>> LOG2_WIN);
`endif

  // A tag only strobes if the window was full once this sample landed.
  assign fire = vld_pipe[1] & tag_pipe[1] & filled_s2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x1 <= '0; x2 <= '0; cnt <= '0; d_s1 <= '0;
      vld_pipe <= '0; tag_pipe <= '0;
      wp <= '0; sum <= '0; filled <= 1'b0; filled_s2 <= 1'b0;
      out_q <= '0; out_vld <= 1'b0;
    end else if (CLR) begin
      x1 <= '0; x2 <= '0; cnt <= '0; d_s1 <= '0;
      vld_pipe <= '0; tag_pipe <= '0;
      wp <= '0; sum <= '0; filled <= 1'b0; filled_s2 <= 1'b0;
      out_q <= '0; out_vld <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], bus.IN_VALID};
      tag_pipe <= {tag_pipe[0], bus.IN_VALID & (cnt == CNT_LAST)};
      if (bus.IN_VALID) begin
        d_s1 <= d_nxt;
        x2   <= x1;
        x1   <= bus.IN;
        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
      if (vld_pipe[0]) begin
        sum       <= sum_nxt;
        wp        <= wp + LOG2_WIN'(1);
        filled_s2 <= filled | (wp == WP_LAST);
        if (wp == WP_LAST) filled <= 1'b1;
      end
      out_vld <= fire;
      if (fire) out_q <= out_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < WIN; i++) win_mem[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < WIN; i++) win_mem[i] <= '0;
    end else if (vld_pipe[0]) begin
      win_mem[wp] <= d_s1;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = out_vld;
  assign bus.FILLED    = filled;
endmodule

// File: tb/tb_decim_avg_filter.sv
// Scoreboard bench: default-config DUT (a) and IN_W=8 pass-through-FIR, DECIM=16 DUT (b).
`timescale 1ns/1ps
module tb_decim_avg_filter;
  localparam int WIN = 64;

  typedef struct {int val; int cyc;} exp_t;

  logic CLK = 1'b0, RST = 1'b0, CLR = 1'b0;
  always #5 CLK = ~CLK;

  decim_avg_filter_if #(.IN_W(1), .OUT_W(8)) ifa ();
  decim_avg_filter_if #(.IN_W(8), .OUT_W(8)) ifb ();

  decim_avg_filter dut_a (.CLK(CLK), .RST(RST), .CLR(CLR), .bus(ifa));
  decim_avg_filter #(.IN_W(8), .A0(1), .A1(0), .A2(0), .DECIM(16))
    dut_b (.CLK(CLK), .RST(RST), .CLR(CLR), .bus(ifb));

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // reference model state
  int   ca  [2][3] = '{'{1, -2, 1}, '{1, 0, 0}};
  int   dec [2]    = '{64, 16};
  int   mx1 [2], mx2 [2], mcnt [2], mn [2];
  int   dq  [2][$];
  exp_t eq  [2][$];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int s);
    return (s >= 0) ? s / WIN : -((-s + WIN - 1) / WIN);
  endfunction

  function automatic int shape(input int a);
`ifdef DECIM_AVG_SAT_EN
    return (a > 127) ? 127 : (a < -128) ? -128 : a;
`else
    int w;
    w = a & 255;
    return (w > 127) ? w - 256 : w;
`endif
  endfunction

  task automatic model(input int k, input int x);
    int d, s;
    exp_t e;
    d = ca[k][0] * x + ca[k][1] * mx1[k] + ca[k][2] * mx2[k];
    mx2[k] = mx1[k];
    mx1[k] = x;
    mn[k]++;
    dq[k].push_back(d);
    if (dq[k].size() > WIN) void'(dq[k].pop_front());
    s = 0;
    foreach (dq[k][i]) s += dq[k][i];
    if (mcnt[k] == dec[k] - 1) begin
      mcnt[k] = 0;
      if (mn[k] >= WIN) begin
        e.val = shape(floor_div(s));
        e.cyc = cyc + 3;
        eq[k].push_back(e);
      end
    end else mcnt[k]++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx1[k] = 0; mx2[k] = 0; mcnt[k] = 0; mn[k] = 0;
      dq[k].delete();
    end
  endtask

  // drop expected strobes that a clear/reset will kill
  task automatic flush(input int lim);
    for (int k = 0; k < 2; k++)
      while (eq[k].size() > 0 && eq[k][eq[k].size()-1].cyc > lim) void'(eq[k].pop_back());
  endtask

  task automatic step(input bit va, input int xa, input bit vb, input int xb);
    @(posedge CLK); #1;
    ifa.IN_VALID = va; ifa.IN = 1'(xa);
    ifb.IN_VALID = vb; ifb.IN = 8'(xb);
    if (va) model(0, xa & 1);
    if (vb) model(1, xb & 255);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_out"},    int'(ifa.OUT), 0);
    check({tag, "_a_valid"},  int'(ifa.OUT_VALID), 0);
    check({tag, "_a_filled"}, int'(ifa.FILLED), 0);
    check({tag, "_b_out"},    int'(ifb.OUT), 0);
    check({tag, "_b_valid"},  int'(ifb.OUT_VALID), 0);
    check({tag, "_b_filled"}, int'(ifb.FILLED), 0);
  endtask

  task automatic mon(input int k, input logic v, input logic signed [7:0] o, input logic f);
    exp_t e;
    while (eq[k].size() > 0 && eq[k][0].cyc < cyc) begin
      nvec++; nerr++;
      $display("FAIL strobe_missing dut%0d: no OUT_VALID at cycle %0d, expected OUT=%0d",
               k, eq[k][0].cyc, eq[k][0].val);
      void'(eq[k].pop_front());
    end
    if (v) begin
      if (eq[k].size() == 0) begin
        nvec++; nerr++;
        $display("FAIL strobe_unexpected dut%0d: OUT_VALID=1 OUT=%0d at cycle %0d, expected none",
                 k, o, cyc);
      end else begin
        e = eq[k].pop_front();
        check($sformatf("strobe_cycle_dut%0d", k), cyc, e.cyc);
        check($sformatf("strobe_out_dut%0d", k), int'(o), e.val);
        check($sformatf("filled_at_strobe_dut%0d", k), int'(f), 1);
      end
    end
  endtask

  always @(negedge CLK) begin
    mon(0, ifa.OUT_VALID, ifa.OUT, ifa.FILLED);
    mon(1, ifb.OUT_VALID, ifb.OUT, ifb.FILLED);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.IN_VALID = 1'b0; ifa.IN = '0;
    ifb.IN_VALID = 1'b0; ifb.IN = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 check_zero("reset");
    RST = 1'b1;

    // fill boundary: 63 samples leave FILLED low, the 64th raises it
    repeat (63) step(1, 1, 1, 100);
    repeat (3) step(0, 0, 0, 0);
    check("filled_63_a", int'(ifa.FILLED), 0);
    check("filled_63_b", int'(ifb.FILLED), 0);
    step(1, 1, 1, 100);
    repeat (3) step(0, 0, 0, 0);
    check("filled_64_a", int'(ifa.FILLED), 1);
    check("filled_64_b", int'(ifb.FILLED), 1);
    repeat (200) step(1, 1, 1, 100);

    // out-of-range average (saturate or wrap)
    repeat (150) step(1, 1, 1, 200);

    // half-rate acceptance
    for (int i = 0; i < 200; i++) step(i % 2 == 0, 1, i % 2 == 0, 200);

    // CLR with a concurrent sample: sample dropped, everything cleared
    repeat (6) step(1, $urandom_range(0, 1), 1, $urandom_range(0, 255));
    @(posedge CLK); #1;
    CLR = 1'b1;
    ifa.IN_VALID = 1'b1; ifa.IN = 1'b1;
    ifb.IN_VALID = 1'b1; ifb.IN = 8'd50;
    flush(cyc);
    model_reset();
    @(posedge CLK); #1;
    CLR = 1'b0; ifa.IN_VALID = 1'b0; ifb.IN_VALID = 1'b0;
    check_zero("clr");

    // random data and random gaps
    repeat (500) step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 255));

    // asynchronous reset in mid-cycle
    @(posedge CLK); #1;
    ifa.IN_VALID = 1'b0; ifb.IN_VALID = 1'b0;
    #2 RST = 1'b0;
    flush(cyc - 1);
    model_reset();
    #1 check_zero("async_rst");
    @(posedge CLK); #2 RST = 1'b1;

    // zero history then a step to ones
    repeat (64) step(1, 0, 1, 0);
    repeat (140) step(1, 1, 1, $urandom_range(0, 255));

    repeat (6) step(0, 0, 0, 0);
    check("pending_a", eq[0].size(), 0);
    check("pending_b", eq[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
